change_dispenser: RTL and testbench

- Downstream stage of the vending FSM: takes the change amount the FSM produces on cancel or after a sale and pays it out one coin at a time through the coin hopper.
- Greedy payout in denominations 10/5/1, with fallback when a hopper tube is empty.
- Per-coin request/acknowledge handshake with the hopper, an acknowledge timeout and a fault/clear path.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/change_dispenser_coin_select.sv | 37 +++
 rtl/change_dispenser.sv | 141 ++++++++++++++
 tb/tb_change_dispenser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine: dispenser states, coin codes,
// denomination values and drink prices.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } disp_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_10   = 2'b11;

    localparam int unsigned DENOM_10 = 10;
    localparam int unsigned DENOM_5  = 5;
    localparam int unsigned DENOM_1  = 1;

    localparam int unsigned PRICE_A = 10;
    localparam int unsigned PRICE_B = 15;
    localparam int unsigned PRICE_C = 20;
    localparam int unsigned PRICE_D = 25;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy picker: largest denomination that fits the remaining amount and
// whose hopper tube still has coins.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMOUNT_W = 32
) (
    input  logic [AMOUNT_W-1:0] remaining,
    input  logic                empty_10,
    input  logic                empty_5,
    input  logic                empty_1,
    output logic [1:0]          coin_type,
    output logic [AMOUNT_W-1:0] coin_value,
    output logic                none_avail
);

    // Priority 10 > 5 > 1, skipping empty tubes and coins larger than owed
    always_comb begin
        coin_type  = COIN_NONE;
        coin_value = '0;
        none_avail = 1'b1;
        if (!empty_10 && remaining >= AMOUNT_W'(DENOM_10)) begin
            coin_type  = COIN_10;
            coin_value = AMOUNT_W'(DENOM_10);
            none_avail = 1'b0;
        end else if (!empty_5 && remaining >= AMOUNT_W'(DENOM_5)) begin
            coin_type  = COIN_5;
            coin_value = AMOUNT_W'(DENOM_5);
            none_avail = 1'b0;
        end else if (!empty_1 && remaining >= AMOUNT_W'(DENOM_1)) begin
            coin_type  = COIN_1;
            coin_value = AMOUNT_W'(DENOM_1);
            none_avail = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time through the hopper using a
// per-coin req/ack handshake, with an ack timeout and a fault/clear path.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMOUNT_W = 32,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AMOUNT_W-1:0] change_amount,
    input  logic                change_valid,
    output logic                change_ready,
    input  logic                empty_10,
    input  logic                empty_5,
    input  logic                empty_1,
    output logic                coin_req,
    output logic [1:0]          coin_type,
    input  logic                coin_ack,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [CNT_W-1:0]    coin_count,
    output logic                done,
    output logic                fault,
    input  logic                clear
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    disp_state_t         state, state_nxt;
    logic [AMOUNT_W-1:0] remaining_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic [1:0]          type_nxt;
    logic [AMOUNT_W-1:0] coin_val, coin_val_nxt;
    logic [TMO_W-1:0]    tmo, tmo_nxt;

    logic [1:0]          sel_type;
    logic [AMOUNT_W-1:0] sel_value;
    logic                sel_none;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    coin_select #(.AMOUNT_W(AMOUNT_W)) u_coin_select (
        .remaining  (remaining),
        .empty_10   (empty_10),
        .empty_5    (empty_5),
        .empty_1    (empty_1),
        .coin_type  (sel_type),
        .coin_value (sel_value),
        .none_avail (sel_none)
    );

    assign change_ready = (state == ST_IDLE);

    // Next-state and next datapath values
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        count_nxt     = coin_count;
        type_nxt      = coin_type;
        coin_val_nxt  = coin_val;
        tmo_nxt       = tmo;
        case (state)
            ST_IDLE: begin
                if (change_valid) begin
                    remaining_nxt = change_amount;
                    count_nxt     = '0;
                    state_nxt     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remaining == '0) begin
                    state_nxt = ST_DONE;
                end else if (sel_none) begin
                    state_nxt = ST_FAULT;
                end else begin
                    type_nxt     = sel_type;
                    coin_val_nxt = sel_value;
                    tmo_nxt      = '0;
                    state_nxt    = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                // An ack arriving on the expiry cycle still counts as delivered
                if (coin_ack) begin
                    remaining_nxt = remaining - coin_val;
                    count_nxt     = sat_inc(coin_count);
                    type_nxt      = COIN_NONE;
                    state_nxt     = ST_SELECT;
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    type_nxt  = COIN_NONE;
                    state_nxt = ST_FAULT;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                type_nxt  = COIN_NONE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Registered outputs and datapath; flags are decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining  <= '0;
            coin_count <= '0;
            coin_type  <= COIN_NONE;
            coin_val   <= '0;
            tmo        <= '0;
            coin_req   <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            remaining  <= remaining_nxt;
            coin_count <= count_nxt;
            coin_type  <= type_nxt;
            coin_val   <= coin_val_nxt;
            tmo        <= tmo_nxt;
            coin_req   <= (state_nxt == ST_DISPENSE);
            done       <= (state_nxt == ST_DONE);
            fault      <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of payouts plus
// hand-written sequences for zero change, timeout, busy and reset cases.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] change_amount;
    logic        change_valid;
    logic        change_ready;
    logic        empty_10, empty_5, empty_1;
    logic        coin_req;
    logic [1:0]  coin_type;
    logic        coin_ack;
    logic [31:0] remaining;
    logic [7:0]  coin_count;
    logic        done;
    logic        fault;
    logic        clear;

    int n_cmp  = 0;
    int n_fail = 0;

    change_dispenser #(.AMOUNT_W(32), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .change_amount (change_amount),
        .change_valid  (change_valid),
        .change_ready  (change_ready),
        .empty_10      (empty_10),
        .empty_5       (empty_5),
        .empty_1       (empty_1),
        .coin_req      (coin_req),
        .coin_type     (coin_type),
        .coin_ack      (coin_ack),
        .remaining     (remaining),
        .coin_count    (coin_count),
        .done          (done),
        .fault         (fault),
        .clear         (clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] amt;
        logic        e10, e5, e1;
        logic [31:0] exp_codes;
        int          exp_n;
        logic        exp_fault;
        logic [31:0] exp_rem;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request and act as a hopper that acks one cycle after each req
    task automatic run_txn(input logic [31:0] amt, input logic e10, input logic e5, input logic e1,
                           output logic [31:0] codes, output int ncoins, output int ndone,
                           output logic saw_fault, output logic finished);
        codes = '0; ncoins = 0; ndone = 0; saw_fault = 1'b0; finished = 1'b0;
        empty_10 = e10; empty_5 = e5; empty_1 = e1;
        change_amount = amt;
        change_valid  = 1'b1;
        tick();
        change_valid  = 1'b0;
        change_amount = 32'hDEAD;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin ndone++; finished = 1'b1; break; end
            if (fault) begin saw_fault = 1'b1; finished = 1'b1; break; end
            if (coin_req && !coin_ack) begin
                if (ncoins < 16) codes = codes | (32'(coin_type) << (2 * ncoins));
                ncoins++;
                coin_ack = 1'b1;
            end else begin
                coin_ack = 1'b0;
            end
            tick();
        end
        coin_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] codes;
        int          ncoins, ndone, reqs;
        logic        sfault, fin;

        vecs[0] = '{32'd27, 1'b0, 1'b0, 1'b0, 32'h16F,   5, 1'b0, 32'd0, 8'd5};
        vecs[1] = '{32'd20, 1'b1, 1'b0, 1'b0, 32'hAA,    4, 1'b0, 32'd0, 8'd4};
        vecs[2] = '{32'd7,  1'b0, 1'b0, 1'b1, 32'h2,     1, 1'b1, 32'd2, 8'd1};
        vecs[3] = '{32'd16, 1'b0, 1'b0, 1'b0, 32'h1B,    3, 1'b0, 32'd0, 8'd3};
        vecs[4] = '{32'd9,  1'b0, 1'b1, 1'b0, 32'h15555, 9, 1'b0, 32'd0, 8'd9};
        vecs[5] = '{32'd3,  1'b0, 1'b0, 1'b1, 32'h0,     0, 1'b1, 32'd3, 8'd0};
        vecs[6] = '{32'd6,  1'b1, 1'b0, 1'b0, 32'h6,     2, 1'b0, 32'd0, 8'd2};
        vecs[7] = '{32'd11, 1'b0, 1'b1, 1'b0, 32'h7,     2, 1'b0, 32'd0, 8'd2};

        reset = 1'b0; change_amount = '0; change_valid = 1'b0;
        empty_10 = 1'b0; empty_5 = 1'b0; empty_1 = 1'b0;
        coin_ack = 1'b0; clear = 1'b0;
        tick(); tick();
        check("rst_remaining", remaining, 0);
        check("rst_count", 32'(coin_count), 0);
        check("rst_req", 32'(coin_req), 0);
        check("rst_type", 32'(coin_type), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_ready", 32'(change_ready), 1);
        reset = 1'b1;
        tick();

        // Table-driven payouts
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].amt, vecs[i].e10, vecs[i].e5, vecs[i].e1, codes, ncoins, ndone, sfault, fin);
            check($sformatf("v%0d_finished", i), 32'(fin), 1);
            check($sformatf("v%0d_codes", i), codes, vecs[i].exp_codes);
            check($sformatf("v%0d_ncoins", i), ncoins, vecs[i].exp_n);
            check($sformatf("v%0d_fault", i), 32'(sfault), 32'(vecs[i].exp_fault));
            check($sformatf("v%0d_done", i), ndone, vecs[i].exp_fault ? 0 : 1);
            check($sformatf("v%0d_remaining", i), remaining, vecs[i].exp_rem);
            check($sformatf("v%0d_count", i), 32'(coin_count), 32'(vecs[i].exp_cnt));
            if (sfault) begin
                tick();
                check($sformatf("v%0d_fault_held", i), 32'(fault), 1);
                clear = 1'b1;
                tick();
                clear = 1'b0;
                check($sformatf("v%0d_clr_fault", i), 32'(fault), 0);
                check($sformatf("v%0d_clr_ready", i), 32'(change_ready), 1);
                check($sformatf("v%0d_clr_rem_kept", i), remaining, vecs[i].exp_rem);
            end else begin
                tick();
                check($sformatf("v%0d_done_1cyc", i), 32'(done), 0);
                check($sformatf("v%0d_ready", i), 32'(change_ready), 1);
            end
            empty_10 = 1'b0; empty_5 = 1'b0; empty_1 = 1'b0;
            tick();
        end

        // Zero change: done after the 2nd edge counting the accept edge
        change_amount = 32'd0; change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        check("z_done_early", 32'(done), 0);
        check("z_req0", 32'(coin_req), 0);
        tick();
        check("z_done", 32'(done), 1);
        check("z_req1", 32'(coin_req), 0);
        tick();
        check("z_done_off", 32'(done), 0);
        check("z_ready", 32'(change_ready), 1);

        // Timeout: no ack for 16 req cycles
        change_amount = 32'd10; change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        reqs = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (fault) break;
            if (coin_req) reqs++;
            tick();
        end
        check("to_req_cycles", reqs, 16);
        check("to_fault", 32'(fault), 1);
        check("to_req_low", 32'(coin_req), 0);
        check("to_remaining", remaining, 10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("to_clear_ready", 32'(change_ready), 1);

        // Ack on the 16th req cycle beats the timeout
        change_amount = 32'd10; change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        reqs = 0; ndone = 0; sfault = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done) begin ndone++; break; end
            if (fault) begin sfault = 1'b1; break; end
            if (coin_req) reqs++;
            coin_ack = (coin_req && reqs == 16);
            tick();
        end
        coin_ack = 1'b0;
        check("late_ack_done", ndone, 1);
        check("late_ack_fault", 32'(sfault), 0);
        check("late_ack_rem", remaining, 0);
        check("late_ack_count", 32'(coin_count), 1);
        tick(); tick();

        // Busy: valid pulses while dispensing are ignored, then async reset
        change_amount = 32'd10; change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        tick();
        check("busy_req", 32'(coin_req), 1);
        check("busy_ready", 32'(change_ready), 0);
        change_amount = 32'd99; change_valid = 1'b1;
        tick(); tick();
        change_valid = 1'b0;
        check("busy_rem", remaining, 10);
        check("busy_req_held", 32'(coin_req), 1);
        check("busy_type_held", 32'(coin_type), 32'(2'b11));
        #2;
        reset = 1'b0;
        #1;
        check("async_req", 32'(coin_req), 0);
        check("async_rem", remaining, 0);
        check("async_fault", 32'(fault), 0);
        check("async_ready", 32'(change_ready), 1);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_ready", 32'(change_ready), 1);
        check("post_rst_req", 32'(coin_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
